// File: rtl/imem_loader_pkg.sv
// Shared constants and encodings for the serial instruction loader.
// Defaults here are what the top-level parameters fall back to.
package imem_loader_pkg;

    localparam int          P_CLK_HZ    = 50_000_000;
    localparam int          P_BAUD      = 115200;
    localparam int          P_IMEM_SIZE = 64;
    localparam logic [7:0]  P_HDR       = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver with 16x oversampling; RXD is synchronized here.
// Emits a one-cycle rx_valid (good stop) or rx_ferr (low stop) per byte.
module uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLK_HZ = P_CLK_HZ,
    parameter int BAUD   = P_BAUD
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int DIV = (CLK_HZ / (BAUD * 16)) < 1 ? 1 : CLK_HZ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    rx_state_t   state, state_n;
    logic [1:0]  sync;
    logic        rxd_s, rxd_prev;
    logic [DW-1:0] div_cnt, div_n;
    logic [3:0]  tck, tck_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shreg, sh_n, byte_n;
    logic        valid_n, ferr_n;
    logic        tick, fall;

    assign rxd_s = sync[1];
    assign tick  = (div_cnt == DW'(DIV - 1));
    assign fall  = rxd_prev & ~rxd_s;

    always_comb begin
        state_n = state;
        div_n   = tick ? '0 : div_cnt + 1'b1;
        tck_n   = tick ? tck + 4'd1 : tck;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        byte_n  = rx_byte;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                // divider restarts on the start edge so ticks line up with bit centres
                div_n = '0;
                tck_n = '0;
                if (fall) state_n = RX_START;
            end
            RX_START: begin
                if (tick && tck == 4'd7) begin
                    if (!rxd_s) begin
                        state_n = RX_DATA;
                        tck_n   = '0;
                        bit_n   = '0;
                    end else begin
                        state_n = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (tick && tck == 4'd15) begin
                    sh_n  = {rxd_s, shreg[7:1]};
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && tck == 4'd15) begin
                    if (rxd_s) begin
                        valid_n = 1'b1;
                        byte_n  = shreg;
                    end else begin
                        ferr_n  = 1'b1;
                    end
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync     <= 2'b11;
            rxd_prev <= 1'b1;
            state    <= RX_IDLE;
            div_cnt  <= '0;
            tck      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            sync     <= {sync[0], rxd};
            rxd_prev <= rxd_s;
            state    <= state_n;
            div_cnt  <= div_n;
            tck      <= tck_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
            rx_byte  <= byte_n;
            rx_valid <= valid_n;
            rx_ferr  <= ferr_n;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Frame loader: HDR, N, 4N big-endian data bytes, XOR checksum.
// Drives the IF write port one word at a time and holds LOADING while busy.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         CLK_HZ    = P_CLK_HZ,
    parameter int         BAUD      = P_BAUD,
    parameter int         IMEM_SIZE = P_IMEM_SIZE,
    parameter logic [7:0] HDR       = P_HDR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RXD,
    output logic        WE,
    output logic [31:0] W_Ins,
    output logic [31:0] W_Addr,
    output logic        LOADING,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  WCNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CSUM  = 3'd3,
        S_FIN   = 3'd4
    } ld_state_t;

    localparam logic [8:0] MAXN = 9'(IMEM_SIZE);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .CLK      (CLK),
        .RST      (RST),
        .rxd      (RXD),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    ld_state_t   st, st_n;
    logic        we_n, load_n, done_n, err_n;
    logic [31:0] ins_n, addr_n;
    logic [7:0]  wcnt_n, csum, csum_n, word_idx, idx_n, nwords, nw_n;
    logic [1:0]  byte_cnt, bc_n;
    logic [23:0] asm_r, asm_n;
    logic        hdr_hit;

    assign hdr_hit = rx_valid && (rx_byte == HDR);

    always_comb begin
        st_n   = st;
        we_n   = 1'b0;
        ins_n  = W_Ins;
        addr_n = W_Addr;
        load_n = LOADING;
        done_n = DONE;
        err_n  = ERR;
        wcnt_n = WCNT;
        csum_n = csum;
        idx_n  = word_idx;
        bc_n   = byte_cnt;
        asm_n  = asm_r;
        nw_n   = nwords;
        case (st)
            S_IDLE, S_FIN: begin
                if (hdr_hit) begin
                    done_n = 1'b0;
                    err_n  = 1'b0;
                    wcnt_n = '0;
                    csum_n = '0;
                    idx_n  = '0;
                    bc_n   = '0;
                    load_n = 1'b1;
                    st_n   = S_COUNT;
                end
            end
            S_COUNT: begin
                if (rx_valid) begin
                    if (rx_byte == 8'd0 || {1'b0, rx_byte} > MAXN) begin
                        err_n  = 1'b1;
                        load_n = 1'b0;
                        st_n   = S_FIN;
                    end else begin
                        nw_n = rx_byte;
                        st_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    csum_n = csum ^ rx_byte;
                    asm_n  = {asm_r[15:0], rx_byte};
                    bc_n   = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        we_n   = 1'b1;
                        ins_n  = {asm_r, rx_byte};
                        addr_n = {22'd0, word_idx, 2'b00};
                        idx_n  = word_idx + 8'd1;
                        wcnt_n = WCNT + 8'd1;
                        if (word_idx + 8'd1 == nwords) st_n = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_byte == csum) done_n = 1'b1;
                    else                 err_n  = 1'b1;
                    load_n = 1'b0;
                    st_n   = S_FIN;
                end
            end
            default: st_n = S_IDLE;
        endcase
        // a corrupted byte mid-frame abandons the frame; written words stay
        if (rx_ferr && (st == S_COUNT || st == S_DATA || st == S_CSUM)) begin
            err_n  = 1'b1;
            load_n = 1'b0;
            st_n   = S_FIN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st       <= S_IDLE;
            WE       <= 1'b0;
            W_Ins    <= '0;
            W_Addr   <= '0;
            LOADING  <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            WCNT     <= '0;
            csum     <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            asm_r    <= '0;
            nwords   <= '0;
        end else begin
            st       <= st_n;
            WE       <= we_n;
            W_Ins    <= ins_n;
            W_Addr   <= addr_n;
            LOADING  <= load_n;
            DONE     <= done_n;
            ERR      <= err_n;
            WCNT     <= wcnt_n;
            csum     <= csum_n;
            word_idx <= idx_n;
            byte_cnt <= bc_n;
            asm_r    <= asm_n;
            nwords   <= nw_n;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: UART byte driver, write scoreboard, status checks.
// Clock/baud chosen so the tick divider is 2 (32 cycles per bit).
module tb_imem_loader;

    localparam int CLK_HZ = 3_686_400;
    localparam int BAUD   = 115200;
    localparam int BIT    = 16 * (CLK_HZ / (BAUD * 16));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        we, loading, done, err;
    logic [31:0] w_ins, w_addr;
    logic [7:0]  wcnt;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
        logic [7:0]  cnt;
    } wr_t;

    wr_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  rxv_cnt = 0;

    imem_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .IMEM_SIZE(64), .HDR(8'hA5)) dut (
        .CLK     (clk),
        .RST     (rst),
        .RXD     (rxd),
        .WE      (we),
        .W_Ins   (w_ins),
        .W_Addr  (w_addr),
        .LOADING (loading),
        .DONE    (done),
        .ERR     (err),
        .WCNT    (wcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // write monitor: every WE must match the oldest expected write
    always @(negedge clk) begin
        if (dut.u_rx.rx_valid) rxv_cnt++;
        if (we) begin
            if (sb.size() == 0) begin
                chk("we_unexpected", {31'd0, we}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("w_addr", w_addr, e.addr);
                chk("w_ins", w_ins, e.ins);
                chk("wcnt_at_we", {24'd0, wcnt}, {24'd0, e.cnt});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(BIT);
        end
        rxd = stop;
        idle(BIT);
        rxd = 1'b1;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] c);
        wr_t e;
        e.addr = a;
        e.ins  = d;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    task automatic load_frame(input logic [31:0] w0, input logic [31:0] w1, input logic bad);
        logic [7:0] cs;
        logic [31:0] w[2];
        w[0] = w0;
        w[1] = w1;
        cs = 8'h00;
        push_wr(32'd0, w0, 8'd1);
        push_wr(32'd4, w1, 8'd2);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        chk("loading_busy", {31'd0, loading}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            for (int j = 3; j >= 0; j--) begin
                cs = cs ^ w[k][8*j +: 8];
                send_byte(w[k][8*j +: 8], 1'b1);
            end
        end
        send_byte(bad ? 8'h00 : cs, 1'b1);
        idle(4);
        chk("wcnt", {24'd0, wcnt}, 32'd2);
        chk("done", {31'd0, done}, {31'd0, !bad});
        chk("err", {31'd0, err}, {31'd0, bad});
        chk("loading_end", {31'd0, loading}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
    endtask

    task automatic expect_err_nowrite(input string tag);
        chk({tag, "_err"}, {31'd0, err}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_loading"}, {31'd0, loading}, 32'd0);
        chk({tag, "_wcnt"}, {24'd0, wcnt}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_w_ins"}, w_ins, 32'd0);
        chk({tag, "_w_addr"}, w_addr, 32'd0);
        chk({tag, "_loading"}, {31'd0, loading}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_wcnt"}, {24'd0, wcnt}, 32'd0);
    endtask

    initial begin
        int rv0;
        rst = 1'b1;
        rxd = 1'b1;
        idle(5);
        check_all_zero("reset");
        rst = 1'b0;
        idle(10);

        // good frame from the plan, then held outputs
        load_frame(32'h20110100, 32'h0000000C, 1'b0);
        chk("w_ins_held", w_ins, 32'h0000000C);
        chk("w_addr_held", w_addr, 32'd4);

        // bad checksum: writes happen, then ERR
        load_frame(32'h20110100, 32'h0000000C, 1'b1);

        // count out of range on both ends
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(4);
        expect_err_nowrite("n0");
        send_byte(8'hA5, 1'b1);
        send_byte(8'h41, 1'b1);
        idle(4);
        expect_err_nowrite("n65");

        // boundary: N = IMEM_SIZE accepted (stays loading), then abandoned by reset below
        // framing error on third data byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h01, 1'b0);
        idle(4);
        expect_err_nowrite("ferr");
        load_frame(32'hDEADBEEF, 32'h12345678, 1'b0);

        // noise bytes ignored, glitch rejected
        rv0 = rxv_cnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(4);
        chk("noise_rxv", rxv_cnt, rv0 + 2);
        chk("noise_done", {31'd0, done}, 32'd1);
        chk("noise_loading", {31'd0, loading}, 32'd0);
        rv0 = rxv_cnt;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(2 * BIT);
        chk("glitch_rxv", rxv_cnt, rv0);
        chk("glitch_loading", {31'd0, loading}, 32'd0);
        load_frame(32'h20110100, 32'h0000000C, 1'b0);

        // max count accepted
        send_byte(8'hA5, 1'b1);
        send_byte(8'h40, 1'b1);
        idle(4);
        chk("nmax_loading", {31'd0, loading}, 32'd1);
        chk("nmax_err", {31'd0, err}, 32'd0);

        // reset mid-frame after 5 data bytes
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        push_wr(32'd0, 32'hCAFEF00D, 8'd1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hCA, 1'b1);
        send_byte(8'hFE, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'h11, 1'b1);
        chk("pre_rst_wcnt", {24'd0, wcnt}, 32'd1);
        chk("pre_rst_loading", {31'd0, loading}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        chk("mid_rst_sb", sb.size(), 32'd0);
        idle(3);
        rst = 1'b0;
        idle(10);
        load_frame(32'hCAFEF00D, 32'h11223344, 1'b0);

        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial instruction loader sitting directly upstream of the IF stage. It receives a program image over a UART line, assembles big-endian 32-bit words, and drives the IF stage's write port (WE, W_Ins, newPC) one word at a time. It holds the CPU off while loading, then reports completion or error. The top level muxes W_Addr onto IF's newPC while LOADING is high.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency
- BAUD, 115200, UART bit rate
- IMEM_SIZE, from common_param.vh (64), maximum word count accepted
- HDR, 8'hA5, frame header byte

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- RXD  in  1  UART receive line, idle high, asynchronous to CLK
- WE  out  1  one-cycle IMEM write strobe to IF
- W_Ins  out  32  instruction word to IF
- W_Addr  out  32  byte address of the word (word_idx*4); drives IF newPC while LOADING
- LOADING  out  1  high from header acceptance until DONE or ERR; top holds CPU PC update off
- DONE  out  1  sticky, good frame loaded
- ERR  out  1  sticky, frame rejected
- WCNT  out  8  number of words written in the current or last frame

## Operation
- Frame: HDR, N (1..IMEM_SIZE), then 4N data bytes MSB first, then checksum byte = XOR of all 4N data bytes.
- RXD passes through a 2-FF synchronizer before use.
- UART RX, 8N1, 16x oversampling. Tick divider DIV = CLK_HZ/(BAUD*16), truncated (27 at defaults). Start: falling edge, re-check low at tick 8; false start returns to idle. Data bits sampled every 16 ticks, LSB first. Stop bit sampled at mid-bit: high gives a one-cycle rx_valid with rx_byte; low gives a one-cycle rx_ferr and drops the byte.
- Loader FSM states: IDLE, COUNT, DATA, CSUM, FIN.
  - IDLE: ignore any byte other than HDR. On HDR, clear DONE, ERR, WCNT, csum and word_idx; set LOADING; go to COUNT.
  - COUNT: if N==0 or N>IMEM_SIZE, set ERR and go to FIN. Otherwise latch N and go to DATA.
  - DATA: shift the byte into a 32-bit assembler and XOR it into csum. On the 4th byte, pulse WE with W_Ins=word, W_Addr=word_idx<<2, then increment word_idx and WCNT. After word N, go to CSUM.
  - CSUM: byte == csum sets DONE, otherwise sets ERR. Go to FIN. Words already written are not rolled back.
  - FIN: LOADING low. An HDR byte restarts a load exactly as in IDLE; other bytes are ignored.
- rx_ferr in any state other than IDLE/FIN sets ERR, clears LOADING and goes to FIN.
- No timeout. A stalled frame keeps LOADING high until RST or an error.

## Timing
- Reset values: WE=0, W_Ins=0, W_Addr=0, LOADING=0, DONE=0, ERR=0, WCNT=0, FSM=IDLE, RX idle.
- The reset is asynchronous and aborts a load at any point. Only the partial IMEM contents survive.
- All outputs are registered.
- WE is high exactly 1 cycle, in the cycle after rx_valid of the word's 4th byte. W_Ins and W_Addr are valid in that cycle and held until the next write.
- WCNT updates in the same cycle WE is high.
- LOADING rises the cycle after rx_valid(HDR). It falls in the same cycle DONE or ERR rises.
- Byte latency: rx_valid occurs about 9.5 bit times after the start edge, plus 2 cycles of synchronizer delay.
- Back-to-back bytes with no idle gap must be received without loss.

## Structure
- Shared constants go in common_param.vh: IMEM_SIZE, HDR, default CLK_HZ/BAUD.
- FSM state encodings are localparams inside imem_loader.
- One sub-module: uart_rx (synchronizer, tick divider, bit FSM; outputs rx_byte, rx_valid, rx_ferr).
- Top-level newPC mux and CPU hold stay outside this block.

## Test plan
- Good frame A5 02 20 11 01 00 00 00 00 0C, checksum 0x3C:
  - WE pulses twice, writing 0x20110100 at W_Addr 0 and 0x0000000C at W_Addr 4.
  - WCNT=2, then DONE=1, ERR=0, LOADING=0.
- Bad checksum (same frame, last byte 0x00): both writes occur, then ERR=1, DONE=0.
- Count out of range (A5 00, then A5 41 with IMEM_SIZE=64): ERR=1 with no WE pulse in either case.
- Framing error: drive the stop bit low on the 3rd data byte. Required: ERR=1, LOADING=0, WCNT=0, no WE; a following good frame loads and sets DONE.
- Noise and false start:
  - Bytes 00 FF before HDR are ignored.
  - A 4-cycle low glitch on RXD produces no rx_valid.
  - The frame still loads correctly.
- Reset mid-frame: assert RST after 5 data bytes. All outputs go to 0 immediately; a full retransmitted frame then loads with DONE=1.
